bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the `bcd` block. It takes a sign flag plus three BCD digits (hundreds, tens, ones) and produces an N-bit two's-complement binary value with a one-cycle data_ready strobe. It uses reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It sits between keypad/seven-segment entry logic and datapath blocks that consume binary operands.

---
 rtl/bcd_to_binary.sv | 97 +++++++++
 tb/tb_bcd_to_binary.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: converts a signed 3-digit BCD value to N-bit two's complement
// by reverse double-dabble, one shift per cycle, with a one-cycle data_ready strobe.
module bcd_to_binary #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sign,
  input  logic [3:0]   hundreds,
  input  logic [3:0]   tens,
  input  logic [3:0]   ones,
  output logic [N-1:0] binary,
  output logic         data_ready,
  output logic         busy,
  output logic         error
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;
  state_e state_q, state_d;
  logic [11:0] bcd_q, bcd_d, bcd_r, bcd_sh;
  logic [9:0] mag_q, mag_d;
  logic [3:0] cnt_q, cnt_d;
  logic sign_q, sign_d, inv_q, inv_d;
  logic [N-1:0] binary_q, binary_d, mag_ext;
  logic ready_q, ready_d, error_q, error_d;
  logic bad;
  assign bad = hundreds > 4'd9 || tens > 4'd9 || ones > 4'd9;
  assign mag_ext = N'(mag_q);
  assign bcd_r = {1'b0, bcd_q[11:1]};
  // A digit >= 8 after the shift received a carried-in 10 that halves to 5, not 8
  for (genvar d = 0; d < 3; d++) begin : g_adj
    assign bcd_sh[4*d+:4] = bcd_r[4*d+:4] >= 4'd8 ? bcd_r[4*d+:4] - 4'd3 : bcd_r[4*d+:4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      inv_q    <= 1'b0;
      binary_q <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      inv_q    <= inv_d;
      binary_q <= binary_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    inv_d    = inv_q;
    binary_d = binary_q;
    error_d  = error_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = bad ? FINISH : SHIFT;
        bcd_d   = {hundreds, tens, ones};
        mag_d   = '0;
        cnt_d   = '0;
        sign_d  = sign;
        inv_d   = bad;
      end
      SHIFT: begin
        bcd_d   = bcd_sh;
        mag_d   = {bcd_q[0], mag_q[9:1]};
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'd9 ? FINISH : SHIFT;
      end
      FINISH: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        error_d  = inv_q;
        binary_d = inv_q ? '0 : sign_q ? -mag_ext : mag_ext;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy       = state_q != IDLE;
    binary     = binary_q;
    data_ready = ready_q;
    error      = error_q;
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed stimulus with a per-cycle arithmetic reference model
// plus hand-computed literal results for the BCD-to-binary converter.
module tb_bcd_to_binary;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sign = 1'b0;
  logic [3:0] hundreds = '0, tens = '0, ones = '0;
  logic [N-1:0] binary;
  logic data_ready, busy, error;
  int n_checks = 0, n_fail = 0, rdy_cnt = 0;
  bit chk_en = 1'b0;

  bcd_to_binary #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .binary(binary), .data_ready(data_ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: value = +/-(100h+10t+o); result appears 11 edges after acceptance
  // (1 edge for a bad digit); busy for every cycle in between.
  int m_left = 0, m_v = 0;
  logic [N-1:0] m_bin = '0, m_pend = '0;
  logic m_rdy = 1'b0, m_err = 1'b0, m_perr = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_rdy = 1'b0; m_bin = '0; m_err = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_rdy = 1'b1; m_bin = m_pend; m_err = m_perr;
        end
      end else if (start) begin
        m_v    = hundreds * 100 + tens * 10 + ones;
        m_perr = hundreds > 9 || tens > 9 || ones > 9;
        m_pend = m_perr ? '0 : (sign ? N'(-m_v) : N'(m_v));
        m_left = m_perr ? 1 : 11;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("data_ready", 32'(data_ready), 32'(m_rdy));
    chk("binary", 32'(binary), 32'(m_bin));
    chk("error", 32'(error), 32'(m_err));
    if (data_ready) rdy_cnt++;
  end

  task automatic wait_rdy(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!data_ready && lat < 40) begin
      if (busy) bc++;
      @(negedge clk); lat++;
    end
  endtask

  task automatic conv(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                      input logic [N-1:0] eb, input logic ee, input int el);
    int lat, bc;
    @(negedge clk); sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rdy(lat, bc);
    chk("latency", 32'(lat), 32'(el));
    chk("busy_cycles", 32'(bc), 32'(el));
    chk("lit_binary", 32'(binary), 32'(eb));
    chk("lit_error", 32'(error), 32'(ee));
    chk("lit_busy_in_ready", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ready_clears", 32'(data_ready), 32'd0);
  endtask

  initial begin
    int lat, bc, r0;
    repeat (3) @(negedge clk);
    chk("rst_binary", 32'(binary), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    // basic values and boundaries
    conv(1'b1, 4'd1, 4'd6, 4'd2, 16'hFF5E, 1'b0, 11);
    conv(1'b0, 4'd0, 4'd3, 4'd8, 16'h0026, 1'b0, 11);
    conv(1'b0, 4'd9, 4'd9, 4'd9, 16'h03E7, 1'b0, 11);
    conv(1'b1, 4'd9, 4'd9, 4'd9, 16'hFC19, 1'b0, 11);
    conv(1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 11);
    // invalid digit, then recovery
    conv(1'b0, 4'd0, 4'hA, 4'd1, 16'h0000, 1'b1, 1);
    conv(1'b0, 4'd0, 4'd0, 4'd5, 16'h0005, 1'b0, 11);
    // start and input changes during SHIFT are ignored
    r0 = rdy_cnt;
    @(negedge clk); sign = 1'b1; hundreds = 4'd0; tens = 4'd4; ones = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    sign = 1'b0; hundreds = 4'd9; tens = 4'd9; ones = 4'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_rdy(lat, bc);
    chk("ignore_binary", 32'(binary), 32'h0000FFD1);
    repeat (15) @(negedge clk);
    chk("ignore_one_ready", 32'(rdy_cnt - r0), 32'd1);
    // start held high: back-to-back every 12 cycles
    @(negedge clk); sign = 1'b0; hundreds = 4'd1; tens = 4'd2; ones = 4'd3; start = 1'b1;
    @(negedge clk);
    wait_rdy(lat, bc);
    chk("hold_first_binary", 32'(binary), 32'd123);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wait_rdy(lat, bc);
      chk("hold_period", 32'(lat + 1), 32'd12);
      chk("hold_binary", 32'(binary), 32'd123);
    end
    start = 1'b0;
    repeat (14) @(negedge clk);
    // reset in the middle of SHIFT aborts the conversion
    r0 = rdy_cnt;
    @(negedge clk); sign = 1'b0; hundreds = 4'd3; tens = 4'd1; ones = 4'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_binary", 32'(binary), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_ready", 32'(rdy_cnt - r0), 32'd0);
    conv(1'b0, 4'd3, 4'd1, 4'd4, 16'h013A, 1'b0, 11);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
